unmatch_drain_sched: RTL and testbench

Sequencer that drains literal (unmatched) bytes from the 4K x 32-bit unmatch FIFO into the LZ4 sequence emitter. Accepts literal-run commands (byte length, end-of-block flag) from the match engine. Issues FIFO reads word by word with a first-word-fall-through read convention. Forwards words downstream over a valid/ready link with byte-keep on the final word of each run. Sits between the match finder / unmatch FIFO and the token/sequence packer.

---
 rtl/unmatch_drain_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_unmatch_drain_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unmatch_drain_sched.sv
// unmatch_drain_sched
// Drains literal (unmatched) bytes from the unmatch FIFO into the LZ4
// sequence emitter. It takes one literal-run command at a time from the match
// engine, reads the FWFT FIFO word by word, and forwards each word over a
// valid/ready link. The final word of a run carries the byte-keep mask.
//
// Parameters
//   LEN_W        width of the literal-run byte length
//   STALL_LIMIT  consecutive FIFO-empty cycles inside a run before err_stall (1..65535)
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready        run command handshake
//   cmd_len, cmd_eob           run byte length, end-of-block flag
//   fifo_rd_en                 FIFO read strobe (combinational)
//   fifo_dout, fifo_empty      FWFT FIFO data (byte0 = bits[7:0]) and empty flag
//   out_valid/out_ready        downstream handshake
//   out_data, out_keep         literal word, byte enables (bit i -> bits[8i+7:8i])
//   out_last                   final word of an end-of-block run
//   busy                       run in progress or output word pending
//   err_stall                  sticky FIFO starvation error
//
// Optional feature (macro UNMATCH_DRAIN_STAT_EN)
//   Adds stat_bytes (sum of accepted cmd_len) and stat_runs (count of accepted
//   non-empty runs), both 32-bit wrapping counters.

module unmatch_drain_sched #(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_eob,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic             out_last,
  output logic             busy,
  output logic             err_stall
`ifdef UNMATCH_DRAIN_STAT_EN
  ,
  output logic [31:0]      stat_bytes,
  output logic [31:0]      stat_runs
`endif
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned KEEP_W  = 4;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned STAT_W  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    words_left_q, words_left_d;
  logic [KEEP_W-1:0]   last_keep_q, last_keep_d;
  logic                eob_q, eob_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
  logic                out_last_q, out_last_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                err_stall_q, err_stall_d;

  // Command accept; rst is kept out of flop data paths (flops are held in reset anyway).
  logic                accept;
  logic [LEN_W:0]      len_plus3;
  logic [LEN_W-1:0]    cmd_words;
  logic [KEEP_W-1:0]   cmd_keep;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign len_plus3 = {1'b0, cmd_len} + (LEN_W+1)'(3);
  assign cmd_words = LEN_W'(len_plus3 >> 2);

  // Keep mask of the final word from the run length modulo 4.
  always_comb begin
    cmd_keep = 4'b1111;
    case (cmd_len[1:0])
      2'b00:   cmd_keep = 4'b1111;
      2'b01:   cmd_keep = 4'b0001;
      2'b10:   cmd_keep = 4'b0011;
      default: cmd_keep = 4'b0111;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && (cmd_len != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_rd_en && (words_left_q == LEN_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read only when FIFO has data and the output slot is free.
  always_comb begin
    cmd_ready  = 1'b0;
    fifo_rd_en = 1'b0;
    busy       = out_valid_q;
    case (state_q)
      IDLE: begin
        cmd_ready = !rst;
      end
      DRAIN: begin
        fifo_rd_en = !fifo_empty && (!out_valid_q || out_ready);
        busy       = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Datapath next-state: run context, output slot, stall tracking.
  always_comb begin
    words_left_d = words_left_q;
    last_keep_d  = last_keep_q;
    eob_d        = eob_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    stall_cnt_d  = stall_cnt_q;
    err_stall_d  = err_stall_q;

    if (accept) begin
      words_left_d = cmd_words;
      last_keep_d  = cmd_keep;
      eob_d        = cmd_eob;
    end

    if (fifo_rd_en) begin
      out_valid_d  = 1'b1;
      out_data_d   = fifo_dout;
      words_left_d = words_left_q - LEN_W'(1);
      if (words_left_q == LEN_W'(1)) begin
        out_keep_d = last_keep_q;
        out_last_d = eob_q;
      end else begin
        out_keep_d = 4'b1111;
        out_last_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Idle keeps the counter at zero, which covers the clear on DRAIN entry.
    if (state_q == IDLE) begin
      stall_cnt_d = '0;
    end else if (fifo_rd_en) begin
      stall_cnt_d = '0;
    end else if (fifo_empty) begin
      if (stall_cnt_q != STALL_W'(STALL_LIMIT)) begin
        stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
      if (stall_cnt_d == STALL_W'(STALL_LIMIT)) begin
        err_stall_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_left_q <= '0;
      last_keep_q  <= '0;
      eob_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      stall_cnt_q  <= '0;
      err_stall_q  <= 1'b0;
    end else begin
      words_left_q <= words_left_d;
      last_keep_q  <= last_keep_d;
      eob_q        <= eob_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      stall_cnt_q  <= stall_cnt_d;
      err_stall_q  <= err_stall_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign err_stall = err_stall_q;

`ifdef UNMATCH_DRAIN_STAT_EN
  logic [STAT_W-1:0] stat_bytes_q, stat_bytes_d;
  logic [STAT_W-1:0] stat_runs_q, stat_runs_d;

  // Traffic statistics, both wrap modulo 2^32.
  always_comb begin
    stat_bytes_d = stat_bytes_q;
    stat_runs_d  = stat_runs_q;
    if (accept) begin
      stat_bytes_d = stat_bytes_q + STAT_W'(cmd_len);
      if (cmd_len != '0) begin
        stat_runs_d = stat_runs_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bytes_q <= '0;
      stat_runs_q  <= '0;
    end else begin
      stat_bytes_q <= stat_bytes_d;
      stat_runs_q  <= stat_runs_d;
    end
  end

  assign stat_bytes = stat_bytes_q;
  assign stat_runs  = stat_runs_q;
`endif

endmodule

// File: tb/tb_unmatch_drain_sched.sv
// Directed bench for unmatch_drain_sched: a small FWFT FIFO model feeds the
// DUT, outputs are captured on accepted handshakes, and every comparison
// uses hand-computed values.
module tb_unmatch_drain_sched;

  localparam int unsigned LEN_W       = 16;
  localparam int unsigned STALL_LIMIT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_eob;
  logic             fifo_rd_en;
  logic [31:0]      fifo_dout;
  logic             fifo_empty;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [3:0]       out_keep;
  logic             out_last;
  logic             busy;
  logic             err_stall;
`ifdef UNMATCH_DRAIN_STAT_EN
  logic [31:0]      stat_bytes;
  logic [31:0]      stat_runs;
`endif

  always #5 clk = ~clk;

  unmatch_drain_sched #(
    .LEN_W      (LEN_W),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_eob   (cmd_eob),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .busy      (busy),
    .err_stall (err_stall)
`ifdef UNMATCH_DRAIN_STAT_EN
    ,
    .stat_bytes(stat_bytes),
    .stat_runs (stat_runs)
`endif
  );

  // FWFT FIFO model.
  logic [31:0] mem [0:63];
  int          wp = 0;
  int          rp = 0;
  logic        flush = 1'b0;

  assign fifo_empty = (wp == rp);
  assign fifo_dout  = mem[rp % 64];

  // Monitors.
  int          rd_cnt = 0;
  int          bad_rd = 0;
  int          bp_viol = 0;
  int          hold_viol = 0;
  int          ncap = 0;
  logic [31:0] cap_data [0:63];
  logic [3:0]  cap_keep [0:63];
  logic        cap_last [0:63];
  logic        held = 1'b0;
  logic [31:0] hd;
  logic [3:0]  hk;
  logic        hl;

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (fifo_rd_en && !fifo_empty) rp <= rp + 1;
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
    if (fifo_rd_en && out_valid && !out_ready) bp_viol <= bp_viol + 1;
    if (!rst && out_valid && out_ready) begin
      cap_data[ncap % 64] <= out_data;
      cap_keep[ncap % 64] <= out_keep;
      cap_last[ncap % 64] <= out_last;
      ncap <= ncap + 1;
    end
    if (held && !rst && ({out_data, out_keep, out_last} !== {hd, hk, hl}))
      hold_viol <= hold_viol + 1;
    held <= !rst && out_valid && !out_ready;
    hd   <= out_data;
    hk   <= out_keep;
    hl   <= out_last;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp % 64] = w;
    wp = wp + 1;
  endtask

  // Single-word run with out_ready held high.
  task automatic run_one(input int len, input logic [31:0] w, input logic [3:0] keep);
    cyc();
    push(w);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_eob   = 1'b0;
    mid();
    chk("one_cmd_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    mid();
    chk("one_rd_en", 32'(fifo_rd_en), 32'd1);
    cyc();
    mid();
    chk("one_data", out_data, w);
    chk("one_keep", 32'(out_keep), 32'(keep));
    chk("one_last", 32'(out_last), 32'd0);
    chk("one_bubble_ready", 32'(cmd_ready), 32'd1);
  endtask

  int r0;
  int n0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_eob   = 1'b0;
    out_ready = 1'b1;

    // Reset values.
    mid();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_keep", 32'(out_keep), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_stall), 32'd0);
    cyc();
    rst = 1'b0;
    mid();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic 10-byte end-of-block run.
    cyc();
    push(32'h03020100);
    push(32'h07060504);
    push(32'h0B0A0908);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(10);
    cmd_eob   = 1'b1;
    r0 = rd_cnt;
    mid();
    chk("b_accept_ready", 32'(cmd_ready), 32'd1);
    chk("b_idle_no_rd", 32'(fifo_rd_en), 32'd0);
    cyc();
    cmd_valid = 1'b0;
    mid();
    chk("b_first_rd", 32'(fifo_rd_en), 32'd1);
    chk("b_drain_ready", 32'(cmd_ready), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    cyc();
    mid();
    chk("b_w0_data", out_data, 32'h03020100);
    chk("b_w0_keep", 32'(out_keep), 32'hF);
    chk("b_w0_last", 32'(out_last), 32'd0);
    chk("b_w1_rd", 32'(fifo_rd_en), 32'd1);
    cyc();
    mid();
    chk("b_w1_data", out_data, 32'h07060504);
    chk("b_w1_keep", 32'(out_keep), 32'hF);
    chk("b_w2_rd", 32'(fifo_rd_en), 32'd1);
    cyc();
    mid();
    chk("b_w2_data", out_data, 32'h0B0A0908);
    chk("b_w2_keep", 32'(out_keep), 32'h3);
    chk("b_w2_last", 32'(out_last), 32'd1);
    chk("b_no_extra_rd", 32'(fifo_rd_en), 32'd0);
    chk("b_ready_after", 32'(cmd_ready), 32'd1);
    cyc();
    mid();
    chk("b_valid_clr", 32'(out_valid), 32'd0);
    chk("b_busy_clr", 32'(busy), 32'd0);
    chk("b_rd_count", 32'(rd_cnt - r0), 32'd3);

    // Length encodings.
    run_one(1, 32'hA1A1A1A1, 4'b0001);
    run_one(2, 32'hA2A2A2A2, 4'b0011);
    run_one(3, 32'hA3A3A3A3, 4'b0111);
    run_one(4, 32'hA4A4A4A4, 4'b1111);

    // Zero-length command: consumed, nothing read or emitted.
    cyc();
    cmd_valid = 1'b1;
    cmd_len   = '0;
    r0 = rd_cnt;
    n0 = ncap;
    mid();
    chk("z_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    mid();
    chk("z_stay_idle", 32'(cmd_ready), 32'd1);
    chk("z_no_rd", 32'(fifo_rd_en), 32'd0);
    chk("z_busy", 32'(busy), 32'd0);
    cyc();
    mid();
    chk("z_rd_count", 32'(rd_cnt - r0), 32'd0);
    chk("z_out_count", 32'(ncap - n0), 32'd0);

    // Backpressure: 8-word run with out_ready pattern 1,0,0,1.
    cyc();
    for (int i = 0; i < 8; i++) push(32'hB0000000 + 32'(i));
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(32);
    cmd_eob   = 1'b0;
    n0 = ncap;
    for (int k = 0; k < 60 && ncap < n0 + 8; k++) begin
      cyc();
      cmd_valid = 1'b0;
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
    end
    out_ready = 1'b1;
    cyc();
    cyc();
    mid();
    chk("bp_count", 32'(ncap - n0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("bp_data", cap_data[(n0 + i) % 64], 32'hB0000000 + 32'(i));
      chk("bp_keep", 32'(cap_keep[(n0 + i) % 64]), 32'hF);
    end
    chk("bp_last", 32'(cap_last[(n0 + 7) % 64]), 32'd0);
    chk("bp_rd_blocked", 32'(bp_viol), 32'd0);
    chk("bp_hold", 32'(hold_viol), 32'd0);
    chk("bp_err", 32'(err_stall), 32'd0);

    // Starvation: 8-byte run with one word available.
    cyc();
    push(32'hC3C2C1C0);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(8);
    cmd_eob   = 1'b1;
    mid();
    chk("s_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    mid();
    chk("s_rd", 32'(fifo_rd_en), 32'd1);
    cyc();
    mid();
    chk("s_w0_data", out_data, 32'hC3C2C1C0);
    chk("s_w0_last", 32'(out_last), 32'd0);
    repeat (15) cyc();
    mid();
    chk("s_err_before", 32'(err_stall), 32'd0);
    chk("s_no_rd_empty", 32'(fifo_rd_en), 32'd0);
    chk("s_busy", 32'(busy), 32'd1);
    cyc();
    mid();
    chk("s_err_at_limit", 32'(err_stall), 32'd1);
    cyc();
    push(32'hC7C6C5C4);
    mid();
    chk("s_resume_rd", 32'(fifo_rd_en), 32'd1);
    cyc();
    mid();
    chk("s_w1_data", out_data, 32'hC7C6C5C4);
    chk("s_w1_keep", 32'(out_keep), 32'hF);
    chk("s_w1_last", 32'(out_last), 32'd1);
    chk("s_err_sticky", 32'(err_stall), 32'd1);
    chk("s_idle", 32'(cmd_ready), 32'd1);

    // Reset mid-run after four words.
    cyc();
    for (int i = 0; i < 10; i++) push(32'hD0000000 + 32'(i));
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(40);
    cmd_eob   = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    rst   = 1'b1;
    flush = 1'b1;
    mid();
    chk("r_out_valid", 32'(out_valid), 32'd0);
    chk("r_out_data", out_data, 32'd0);
    chk("r_out_keep", 32'(out_keep), 32'd0);
    chk("r_out_last", 32'(out_last), 32'd0);
    chk("r_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("r_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_err", 32'(err_stall), 32'd0);
    cyc();
    rst   = 1'b0;
    flush = 1'b0;
    mid();
    chk("r_ready_after", 32'(cmd_ready), 32'd1);
    run_one(4, 32'hE3E2E1E0, 4'b1111);

`ifdef UNMATCH_DRAIN_STAT_EN
    // Statistics since the reset: 4 (above), then 10, 0 and 5 bytes.
    out_ready = 1'b1;
    cyc();
    push(32'hF0F0F0F0);
    push(32'hF1F1F1F1);
    push(32'hF2F2F2F2);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(10);
    cmd_eob   = 1'b0;
    cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    cmd_valid = 1'b1;
    cmd_len   = '0;
    cyc();
    cmd_valid = 1'b0;
    push(32'hF3F3F3F3);
    push(32'hF4F4F4F4);
    cyc();
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(5);
    cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    mid();
    chk("st_bytes", stat_bytes, 32'd19);
    chk("st_runs", stat_runs, 32'd3);
`endif

    cyc();
    mid();
    chk("no_empty_reads", 32'(bad_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
